// File: rtl/xgpon_burst_frame_gen.sv
// Upstream burst frame generator for the XG-PON / 10G Ethernet TX path.
// Emits periodic bursts on a 32-bit AXI4-Stream master: a run of preamble
// words, one delimiter word, then a PRBS-31 payload closed by TLAST,
// followed by an idle gap until the next burst period begins.
module xgpon_burst_frame_gen #(
    parameter logic [31:0] PREAMBLE_WORD  = 32'hAAAAAAAA,
    parameter logic [31:0] DELIMITER_WORD = 32'h05560556,
    parameter logic [30:0] PRBS_SEED      = 31'h7FFFFFFF
) (
    input  logic        axis_tx_clk,
    input  logic        axis_resetn,
    input  logic        enable,
    input  logic [15:0] preamble_length,
    input  logic [15:0] burst_length,
    input  logic [31:0] burst_period,
    input  logic        clear_stats,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic [31:0] burst_count,
    output logic        overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DELIM,
        ST_PAYLOAD,
        ST_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rst_sync_q;
    logic [15:0] pre_len_q, pre_len_d;
    logic [15:0] pay_len_q, pay_len_d;
    logic [31:0] period_q, period_d;
    logic [31:0] period_cnt_q, period_cnt_d;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [30:0] prbs_q, prbs_d;
    logic [31:0] burst_count_q, burst_count_d;
    logic        overrun_q, overrun_d;

    logic        rst_ready;
    logic        beat_valid;
    logic        beat_accept;
    logic        last_beat;
    logic        period_expired;
    logic        period_late;
    logic        start_burst;
    logic [31:0] prbs_word;
    logic [30:0] prbs_adv;

    // Runs the x^31+x^28+1 generator 32 serial steps; the first generated
    // bit lands in bit 31 so the word goes out MSB-first.
    function automatic logic [62:0] prbs_word_step(input logic [30:0] s_in);
        logic [30:0] s;
        logic [31:0] w;
        logic        b;
        s = s_in;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            b         = s[30] ^ s[27];
            w[31 - i] = b;
            s         = {s[29:0], b};
        end
        return {w, s};
    endfunction

    assign {prbs_word, prbs_adv} = prbs_word_step(prbs_q);

    assign rst_ready      = rst_sync_q[1];
    assign beat_valid     = (state_q == ST_PREAMBLE) || (state_q == ST_DELIM) ||
                            (state_q == ST_PAYLOAD);
    assign beat_accept    = beat_valid && m_axis_tready;
    assign last_beat      = (state_q == ST_PAYLOAD) && (beat_cnt_q == pay_len_q - 16'd1);
    // Expired in the cycle whose following edge would start the next burst
    // on schedule (offset period-1 from the first beat).
    assign period_expired = ({1'b0, period_cnt_q} + 33'd1) >= {1'b0, period_q};
    // Late: the handshake is already past the scheduled start of the next burst.
    assign period_late    = period_cnt_q >= period_q;

    // Reset release synchroniser: bursts are held off until two clean edges.
    always_ff @(posedge axis_tx_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // State, configuration, PRBS and statistics registers.
    always_ff @(posedge axis_tx_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q       <= ST_IDLE;
            pre_len_q     <= '0;
            pay_len_q     <= 16'd1;
            period_q      <= '0;
            period_cnt_q  <= '0;
            beat_cnt_q    <= '0;
            prbs_q        <= PRBS_SEED;
            burst_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_len_q     <= pre_len_d;
            pay_len_q     <= pay_len_d;
            period_q      <= period_d;
            period_cnt_q  <= period_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            prbs_q        <= prbs_d;
            burst_count_q <= burst_count_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic: burst sequencing, period tracking and statistics.
    always_comb begin
        state_d       = state_q;
        pre_len_d     = pre_len_q;
        pay_len_d     = pay_len_q;
        period_d      = period_q;
        beat_cnt_d    = beat_cnt_q;
        prbs_d        = prbs_q;
        burst_count_d = burst_count_q;
        overrun_d     = overrun_q;
        start_burst   = 1'b0;
        // Free-running period counter, saturating so a long stall cannot wrap it.
        period_cnt_d  = (&period_cnt_q) ? period_cnt_q : period_cnt_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (rst_ready && enable) begin
                    start_burst = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (beat_accept) begin
                    if (beat_cnt_q == pre_len_q - 16'd1) begin
                        state_d    = ST_DELIM;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 16'd1;
                    end
                end
            end
            ST_DELIM: begin
                if (beat_accept) begin
                    state_d    = ST_PAYLOAD;
                    beat_cnt_d = '0;
                end
            end
            ST_PAYLOAD: begin
                if (beat_accept) begin
                    prbs_d = prbs_adv;
                    if (last_beat) begin
                        burst_count_d = burst_count_q + 32'd1;
                        if (period_late) begin
                            overrun_d = 1'b1;
                        end
                        // On time at period-1 or late: the next burst follows
                        // immediately with no gap cycle.
                        if (period_expired) begin
                            if (enable) begin
                                start_burst = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                if (period_expired) begin
                    if (enable) begin
                        start_burst = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Burst start: configuration is only sampled here, never mid-burst.
        if (start_burst) begin
            pre_len_d    = preamble_length;
            pay_len_d    = (burst_length == 16'd0) ? 16'd1 : burst_length;
            period_d     = burst_period;
            period_cnt_d = '0;
            beat_cnt_d   = '0;
            prbs_d       = PRBS_SEED;
            state_d      = (preamble_length == 16'd0) ? ST_DELIM : ST_PREAMBLE;
        end

        // Clearing wins over a same-cycle increment or overrun set.
        if (clear_stats) begin
            burst_count_d = '0;
            overrun_d     = 1'b0;
        end
    end

    // Stream outputs decode directly from registered state, so they hold
    // steady while a beat is stalled and fall to zero as soon as reset hits.
    always_comb begin
        m_axis_tdata = '0;
        case (state_q)
            ST_PREAMBLE: m_axis_tdata = PREAMBLE_WORD;
            ST_DELIM:    m_axis_tdata = DELIMITER_WORD;
            ST_PAYLOAD:  m_axis_tdata = prbs_word;
            default:     m_axis_tdata = '0;
        endcase
    end

    assign m_axis_tvalid = beat_valid;
    assign m_axis_tkeep  = {4{beat_valid}};
    assign m_axis_tlast  = last_beat;
    assign m_axis_tuser  = 1'b0;
    assign busy          = (state_q != ST_IDLE);
    assign burst_count   = burst_count_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_xgpon_burst_frame_gen.sv
// Self-checking bench for xgpon_burst_frame_gen: directed scenario sequence
// with randomized backpressure, checked against a frame/timing model built
// from the burst rules (word list per burst, bit-recurrence PRBS, period math).
module tb_xgpon_burst_frame_gen;

    localparam logic [31:0] PRE_W = 32'hAAAAAAAA;
    localparam logic [31:0] DEL_W = 32'h05560556;
    localparam logic [30:0] SEED  = 31'h7FFFFFFF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [15:0] preamble_length;
    logic [15:0] burst_length;
    logic [31:0] burst_period;
    logic        clear_stats;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready;
    logic        busy;
    logic [31:0] burst_count;
    logic        overrun;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_count = 0;
    logic        exp_ovr = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] got_first_payload;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xgpon_burst_frame_gen #(
        .PREAMBLE_WORD  (PRE_W),
        .DELIMITER_WORD (DEL_W),
        .PRBS_SEED      (SEED)
    ) dut (
        .axis_tx_clk     (clk),
        .axis_resetn     (resetn),
        .enable          (enable),
        .preamble_length (preamble_length),
        .burst_length    (burst_length),
        .burst_period    (burst_period),
        .clear_stats     (clear_stats),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tready   (m_axis_tready),
        .busy            (busy),
        .burst_count     (burst_count),
        .overrun         (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected word list for one burst. The PRBS is modelled as a bit
    // sequence x[n] = x[n-31] ^ x[n-28], with the seed as the 31 bits of
    // history (seed bit 0 most recent), then packed 32 bits per word.
    function automatic void build_expected(input int pre, input int blen);
        int   eff;
        bit   seq[];
        logic [30:0] sd;
        logic [31:0] w;
        eff = (blen == 0) ? 1 : blen;
        sd  = SEED;
        exp_q.delete();
        for (int i = 0; i < pre; i++) exp_q.push_back(PRE_W);
        exp_q.push_back(DEL_W);
        seq = new[31 + 32 * eff];
        for (int i = 0; i < 31; i++) seq[30 - i] = sd[i];
        for (int n = 31; n < 31 + 32 * eff; n++) seq[n] = seq[n - 31] ^ seq[n - 28];
        for (int k = 0; k < eff; k++) begin
            w = '0;
            for (int b = 0; b < 32; b++) w[31 - b] = seq[31 + 32 * k + b];
            exp_q.push_back(w);
        end
    endfunction

    // Follows one burst beat by beat at the falling edge, checking data,
    // tlast, stall stability and the running statistics.
    task automatic collect_burst(input int pre, input int blen, input int per, input bit rnd,
                                 input bit clr_at_last, input int drop_at,
                                 output int t_first, output int t_last);
        int          idx;
        int          budget;
        int          nexp;
        bit          stalled;
        bit          is_last;
        logic [31:0] held_d;
        logic        held_l;
        idx     = 0;
        budget  = 3000;
        stalled = 0;
        held_d  = '0;
        held_l  = 1'b0;
        t_first = -1;
        t_last  = -1;
        build_expected(pre, blen);
        nexp = exp_q.size();
        while (idx < nexp && budget > 0) begin
            @(negedge clk);
            budget--;
            clear_stats = 1'b0;
            check("burst_count", burst_count, exp_count);
            check("overrun", overrun, exp_ovr);
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid) begin
                if (t_first < 0) t_first = cyc;
                check("tkeep", m_axis_tkeep, 4'hF);
                if (stalled) begin
                    check("stall_data", m_axis_tdata, held_d);
                    check("stall_last", m_axis_tlast, held_l);
                end
                if (m_axis_tready) begin
                    is_last = (idx == nexp - 1);
                    check("data", m_axis_tdata, exp_q[idx]);
                    check("tlast", m_axis_tlast, is_last);
                    if (idx == pre + 1) got_first_payload = m_axis_tdata;
                    if (idx == drop_at) enable = 1'b0;
                    if (is_last) begin
                        t_last = cyc;
                        if (clr_at_last) clear_stats = 1'b1;
                    end
                    idx++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_d  = m_axis_tdata;
                    held_l  = m_axis_tlast;
                end
            end else if (stalled) begin
                check("tvalid_hold", m_axis_tvalid, 1'b1);
                stalled = 0;
            end
        end
        if (idx < nexp) begin
            check("burst_timeout", idx, nexp);
        end else if (clr_at_last) begin
            exp_count = 0;
            exp_ovr   = 1'b0;
        end else begin
            exp_count++;
            if ((t_last - t_first) >= per) exp_ovr = 1'b1;
        end
    endtask

    function automatic int next_start(input int tf, input int tl, input int per);
        return ((tl - tf) >= per) ? tl + 1 : tf + per;
    endfunction

    initial begin
        int          tf, tl, pred, c_en, rel, waited;
        logic [31:0] basic_payload0;

        resetn          = 1'b0;
        enable          = 1'b0;
        preamble_length = 16'd4;
        burst_length    = 16'd8;
        burst_period    = 32'd20;
        clear_stats     = 1'b0;
        m_axis_tready   = 1'b1;
        got_first_payload = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tkeep", m_axis_tkeep, 4'h0);
        check("rst_tdata", m_axis_tdata, 32'h0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tuser", m_axis_tuser, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", burst_count, 32'h0);
        check("rst_overrun", overrun, 1'b0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_tvalid", m_axis_tvalid, 1'b0);

        // Basic bursts, tready held high
        enable = 1'b1;
        c_en   = cyc;
        collect_burst(4, 8, 20, 0, 0, -1, tf, tl);
        check("start_latency", tf, c_en + 1);
        check("burst_cycles", tl - tf, 12);
        basic_payload0 = exp_q[5];
        pred = next_start(tf, tl, 20);
        for (int b = 0; b < 2; b++) begin
            collect_burst(4, 8, 20, 0, 0, -1, tf, tl);
            check("period_basic", tf, pred);
            pred = next_start(tf, tl, 20);
        end

        // Backpressure: random tready
        for (int b = 0; b < 4; b++) begin
            collect_burst(4, 8, 20, 1, 0, -1, tf, tl);
            check("period_bp", tf, pred);
            pred = next_start(tf, tl, 20);
        end

        // Stats clear in the same cycle as the tlast handshake
        collect_burst(4, 8, 20, 0, 1, -1, tf, tl);
        check("period_stats", tf, pred);
        pred = next_start(tf, tl, 20);

        // Degenerate lengths: latched at the next burst start
        preamble_length = 16'd0;
        burst_length    = 16'd0;
        burst_period    = 32'd2;
        for (int b = 0; b < 4; b++) begin
            collect_burst(0, 0, 2, 0, 0, -1, tf, tl);
            check("period_degen", tf, pred);
            check("degen_b2b", tl - tf, 1);
            check("degen_overrun", overrun, 1'b0);
            pred = next_start(tf, tl, 2);
        end

        // Enable drop mid-payload with basic config
        preamble_length = 16'd4;
        burst_length    = 16'd8;
        burst_period    = 32'd20;
        collect_burst(4, 8, 20, 0, 0, 7, tf, tl);
        check("period_drop", tf, pred);
        while (cyc < tf + 30) begin
            @(negedge clk);
            check("drop_tvalid", m_axis_tvalid, 1'b0);
            check("drop_busy", busy, (cyc < tf + 20) ? 1'b1 : 1'b0);
        end
        check("drop_count", burst_count, exp_count);

        // Reset mid-preamble
        enable = 1'b1;
        waited = 0;
        while (!m_axis_tvalid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("pre_start", m_axis_tvalid, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("pre_word", m_axis_tdata, PRE_W);
        resetn = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
        check("mid_rst_tkeep", m_axis_tkeep, 4'h0);
        check("mid_rst_tdata", m_axis_tdata, 32'h0);
        check("mid_rst_tlast", m_axis_tlast, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_count", burst_count, 32'h0);
        check("mid_rst_overrun", overrun, 1'b0);
        exp_count = 0;
        exp_ovr   = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        rel    = cyc;
        collect_burst(4, 8, 20, 0, 0, -1, tf, tl);
        check("restart_delay", ((tf - rel) >= 2) ? 1'b1 : 1'b0, 1'b1);
        check("reseed", got_first_payload, basic_payload0);

        enable = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgpon_burst_frame_gen.md
# xgpon_burst_frame_gen

- Upstream traffic source for the 10G Ethernet/XG-PON transmit path.
- Generates periodic burst frames and presents them on a 32-bit AXI4-Stream master that drives the Ethernet core's TX user interface.
- Each burst is a run of preamble words, one delimiter word, then a PRBS-31 payload ending in TLAST, followed by an idle gap until the next burst period.
- Runs in the TX user clock domain. Burst shape is set by run-time length and period inputs.

## Interface

Parameters:
- PREAMBLE_WORD, 32'hAAAAAAAA: word repeated during preamble.
- DELIMITER_WORD, 32'h05560556: single sync word sent after the preamble.
- PRBS_SEED, 31'h7FFFFFFF: PRBS-31 state loaded at each burst start; must be non-zero.

Ports:
- axis_tx_clk  in  1  TX user clock; the only clock.
- axis_resetn  in  1  asynchronous, active-low reset.
- enable  in  1  level; high = generate bursts.
- preamble_length  in  16  preamble words per burst (0 allowed).
- burst_length  in  16  payload words per burst; 0 treated as 1.
- burst_period  in  32  cycles from one burst's first beat to the next.
- clear_stats  in  1  synchronous clear of burst_count and overrun.
- m_axis_tdata  out  32  stream data; bit 31 is the first serial bit.
- m_axis_tkeep  out  4  always 4'hF while valid, else 4'h0.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  last payload word of a burst.
- m_axis_tuser  out  1  always 0.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high in any state other than IDLE.
- burst_count  out  32  count of completed bursts; wraps at 2^32.
- overrun  out  1  sticky; a burst ended after its period expired.

## Operation

State machine: IDLE, PREAMBLE, DELIM, PAYLOAD, GAP.

- **IDLE:** tvalid=0. When enable is sampled high, latch all three config inputs, load PRBS state = PRBS_SEED, and start the period counter. Go to PREAMBLE, or to DELIM if the latched preamble_length is 0.
- **PREAMBLE:** drive PREAMBLE_WORD. After preamble_length accepted beats, go to DELIM.
- **DELIM:** drive DELIMITER_WORD for one accepted beat, then go to PAYLOAD.
- **PAYLOAD:** drive PRBS words.
  - The PRBS state advances only on an accepted beat.
  - The last beat carries tlast=1.
  - On the tlast handshake, increment burst_count and go to GAP.
- **GAP:** tvalid=0. Wait for the period to expire.
  - Period expires and enable=1: relatch config, reseed the PRBS, start a new burst.
  - Period expires and enable=0: go to IDLE.

PRBS-31 (x^31+x^28+1), applied 32 times per word:
- Each serial step: b = s[30]^s[27]; s = {s[29:0], b}.
- Bits are emitted MSB-first: tdata[31] is the first b of the word.

Config changes take effect only at a burst start; mid-burst changes are ignored.

Deasserting enable mid-burst does not truncate the burst: it completes through tlast, then the block returns to IDLE (via GAP, after the period expires).

## Timing

AXI-Stream handshake:
- A beat transfers when tvalid && tready.
- Once tvalid is asserted, tdata, tlast and tkeep hold stable until accepted.
- tvalid never drops without a handshake, except on reset.

Start latency and burst timing:
- enable is sampled high at edge E; the first beat is presented at the next cycle (E+1). Call this cycle T0.
- The period counter runs every cycle, independent of tready.
- The next burst's first beat appears at T0+burst_period if the tlast handshake happened at or before T0+burst_period-1. No gap cycle is inserted when the tlast handshake is exactly at T0+burst_period-1.
- If the tlast handshake is later, the next burst starts in the cycle after it and overrun is set. T0 is re-based to that cycle.

With tready held high, a burst takes preamble_length+1+L cycles (L = effective payload length). A burst_period at least that large never overruns.

Counters and statistics:
- All counters are 32-bit.
- clear_stats has priority over an increment or overrun set in the same cycle.

Reset (axis_resetn low, any time, including mid-burst):
- Immediately: tvalid=0, tlast=0, tkeep=0, tdata=0, tuser=0, busy=0, burst_count=0, overrun=0, state=IDLE.
- Reset release is synchronised internally. The first burst may start no earlier than 2 cycles after release.

## Test plan

- **Basic burst:** preamble_length=4, burst_length=8, burst_period=20, tready=1, enable pulse then held.
  - Expect 4×AAAAAAAA, 1×05560556, then 8 PRBS words matching the reference model, with tlast on the 13th beat.
  - Expect first beats of successive bursts exactly 20 cycles apart, and burst_count incrementing by one per burst.
- **Backpressure:** random 50% tready on the basic burst.
  - Expect data/tlast stable while stalled and the same word sequence as with tready=1.
  - Expect overrun=1 once any burst exceeds 20 cycles.
- **Degenerate lengths:** preamble_length=0, burst_length=0, burst_period=2.
  - Expect DELIM then one payload beat with tlast, back to back, with overrun=0.
- **Enable drop mid-payload:** expect the burst to finish at tlast, no further tvalid, and busy=0 after the period expires.
- **Reset mid-preamble:** expect all outputs 0 immediately.
  - After release and enable, expect the burst to restart with the PRBS reseeded (first payload word identical to the first payload word of the basic-burst scenario).
- **Stats:** pulse clear_stats in the same cycle as a tlast handshake. Expect burst_count=0 and overrun=0 afterwards.
